udp_tx_packer: RTL and testbench

Application-side UDP transmit buffer manager that sits directly upstream of the `ros2_ether` UDP TX buffer port. It accepts one datagram at a time as a byte stream with destination IP and ports, packs it into the 32-bit TX buffer layout the stack reads, and hands the buffer over with a release pulse. It then stalls the source until the stack returns ownership with a grant pulse.

---
 rtl/udp_tx_packer_pkg.sv | 21 ++
 rtl/udp_tx_packer_if.sv | 17 +
 rtl/udp_txbuf_ram.sv | 30 +++
 rtl/udp_tx_packer.sv | 153 +++++++++++++++
 tb/tb_udp_tx_packer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_packer_pkg.sv
// udp_tx_packer_pkg: shared types and constants for the UDP TX packer.
//   state_t      : packer FSM states
//   HDR_*        : word offsets of the header fields in the TX buffer
//   PAYLOAD_BASE : first payload word
//   maxlen()     : largest payload (bytes) that fits a 2**aw word buffer
package udp_tx_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_H0, ST_H1, ST_H2, ST_REL, ST_WAIT
  } state_t;

  localparam int HDR_DST_IP   = 0;
  localparam int HDR_PORTS    = 1;
  localparam int HDR_LEN      = 2;
  localparam int PAYLOAD_BASE = 3;

  function automatic int maxlen(input int aw);
    return ((1 << aw) - PAYLOAD_BASE) * 4;
  endfunction

endpackage

// File: rtl/udp_tx_packer_if.sv
// udp_tx_packer_if: datagram source stream plus its per-datagram header.
//   master : the application source (drives header, data, valid, last)
//   slave  : the packer (drives s_tready)
interface udp_tx_packer_if;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;

  modport master (output dst_ip, src_port, dst_port, s_tdata, s_tvalid, s_tlast,
                  input  s_tready);
  modport slave  (input  dst_ip, src_port, dst_port, s_tdata, s_tvalid, s_tlast,
                  output s_tready);
endinterface

// File: rtl/udp_txbuf_ram.sv
// udp_txbuf_ram: 2**AWIDTH x 32 TX buffer storage.
//   clk          : write clock
//   we, be       : write enable and per-byte lane enables
//   waddr, wdata : write address / data
//   raddr, rdata : asynchronous read port
module udp_txbuf_ram #(
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/udp_tx_packer.sv
// udp_tx_packer: packs one datagram (byte stream + header) into the 32-bit
// TX buffer read by the UDP stack, releases the buffer with a pulse and
// stalls the source until the stack grants it back.
//   clk, rst          : clock, synchronous active-high reset
//   s                 : source stream + header (udp_tx_packer_if.slave)
//   udp_txbuf_rel     : one-cycle release pulse to the stack
//   udp_txbuf_grant   : one-cycle ownership return from the stack
//   udp_txbuf_addr/ce : stack read port (ce ignored, reads always enabled)
//   udp_txbuf_rdata   : combinational buffer read data
//   overflow          : with rel, payload was truncated to MAXLEN
//   timeout           : grant timeout pulse
// Optional feature: define UDP_TX_PACKER_TIMEOUT_EN to reclaim the buffer
// when no grant arrives within TIMEOUT_CYCLES clocks after release.
module udp_tx_packer
  import udp_tx_packer_pkg::*;
#(
  parameter int AWIDTH         = 6,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic              clk,
  input  logic              rst,
  udp_tx_packer_if.slave    s,
  output logic              udp_txbuf_rel,
  input  logic              udp_txbuf_grant,
  input  logic [AWIDTH-1:0] udp_txbuf_addr,
  input  logic              udp_txbuf_ce,
  output logic [31:0]       udp_txbuf_rdata,
  output logic              overflow,
  output logic              timeout
);

  localparam logic [15:0] MAXLEN = 16'(maxlen(AWIDTH));

  state_t            state, state_nx;
  logic [15:0]       cnt;
  logic              ovf_q;
  logic [31:0]       ip_q, ports_q;
  logic              accept, wait_done;
  logic              we;
  logic [3:0]        be;
  logic [AWIDTH-1:0] waddr;
  logic [31:0]       wdata;
  logic              ce_unused;

  assign ce_unused = udp_txbuf_ce;

`ifdef UDP_TX_PACKER_TIMEOUT_EN
  logic [31:0] wcnt;

  // Counts cycles spent in WAIT; restarts every time WAIT is entered.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) wcnt <= '0;
    else                         wcnt <= wcnt + 32'd1;
  end

  // A grant in the expiry cycle wins over the timeout.
  assign wait_done = (state == ST_WAIT) && (wcnt == 32'(TIMEOUT_CYCLES - 1))
                     && !udp_txbuf_grant;
  assign timeout   = wait_done;
`else
  assign wait_done = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s.s_tready    = 1'b0;
    udp_txbuf_rel = 1'b0;
    overflow      = 1'b0;
    accept        = 1'b0;
    we            = 1'b0;
    be            = 4'h0;
    waddr         = '0;
    wdata         = '0;
    case (state)
      ST_IDLE, ST_FILL: begin
        s.s_tready = 1'b1;
        accept     = s.s_tvalid;
        if (accept) begin
          // Bytes past MAXLEN are swallowed without a write.
          if (cnt < MAXLEN) begin
            we    = 1'b1;
            waddr = AWIDTH'(PAYLOAD_BASE) + AWIDTH'(cnt >> 2);
            // Lane 0 writes the whole word so stale upper lanes read 0.
            be    = (cnt[1:0] == 2'd0) ? 4'hF : (4'b0001 << cnt[1:0]);
            wdata = {24'h0, s.s_tdata} << {cnt[1:0], 3'b000};
          end
          state_nx = s.s_tlast ? ST_H0 : ST_FILL;
        end
      end
      ST_H0: begin
        we = 1'b1; be = 4'hF; waddr = AWIDTH'(HDR_DST_IP); wdata = ip_q;
        state_nx = ST_H1;
      end
      ST_H1: begin
        we = 1'b1; be = 4'hF; waddr = AWIDTH'(HDR_PORTS); wdata = ports_q;
        state_nx = ST_H2;
      end
      ST_H2: begin
        we = 1'b1; be = 4'hF; waddr = AWIDTH'(HDR_LEN); wdata = {16'h0, cnt};
        state_nx = ST_REL;
      end
      ST_REL: begin
        udp_txbuf_rel = 1'b1;
        overflow      = ovf_q;
        state_nx      = ST_WAIT;
      end
      ST_WAIT: begin
        if (udp_txbuf_grant || wait_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Count doubles as the saturated length; cleared when the buffer returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ovf_q   <= 1'b0;
      ip_q    <= '0;
      ports_q <= '0;
    end else begin
      if (state == ST_IDLE && accept) begin
        ip_q    <= s.dst_ip;
        ports_q <= {s.src_port, s.dst_port};
      end
      if (accept) begin
        if (cnt < MAXLEN) cnt   <= cnt + 16'd1;
        else              ovf_q <= 1'b1;
      end
      if (state == ST_WAIT && state_nx == ST_IDLE) begin
        cnt   <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  udp_txbuf_ram #(.AWIDTH(AWIDTH)) u_ram (
    .clk   (clk),
    .we    (we && !rst),
    .be    (be),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (udp_txbuf_addr),
    .rdata (udp_txbuf_rdata)
  );

endmodule

// File: tb/tb_udp_tx_packer.sv
module tb_udp_tx_packer;

  localparam int AW     = 6;
  localparam int MAXLEN = 244;
`ifdef UDP_TX_PACKER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 2**24;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          udp_txbuf_grant = 1'b0;
  logic          udp_txbuf_ce = 1'b1;
  logic [AW-1:0] udp_txbuf_addr = '0;
  logic [31:0]   udp_txbuf_rdata;
  logic          udp_txbuf_rel, overflow, timeout;

  udp_tx_packer_if s_if ();

  udp_tx_packer #(.AWIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .s               (s_if.slave),
    .udp_txbuf_rel   (udp_txbuf_rel),
    .udp_txbuf_grant (udp_txbuf_grant),
    .udp_txbuf_addr  (udp_txbuf_addr),
    .udp_txbuf_ce    (udp_txbuf_ce),
    .udp_txbuf_rdata (udp_txbuf_rdata),
    .overflow        (overflow),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  pl[$];
  logic [31:0] mdl[64];
  int          mdl_nw = 0;

  typedef struct {
    string       txt;
    int          n;
    logic [31:0] ip;
    logic [15:0] sp, dp;
    logic [31:0] w0, w1, w2, w3;
  } vec_t;
  vec_t tv[3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference buffer image: header words, then payload packed little-endian
  // per word with zeros past the (saturated) length.
  task automatic model_pkt(input logic [31:0] ip, input logic [15:0] sp, dp, input int n);
    int len;
    len = (n > MAXLEN) ? MAXLEN : n;
    mdl[0] = ip;
    mdl[1] = {sp, dp};
    mdl[2] = len;
    for (int w = 0; w < (len + 3) / 4; w++) begin
      logic [31:0] word;
      word = 0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < len) word = word | (32'(pl[4*w + k]) << (8*k));
      mdl[3 + w] = word;
    end
    mdl_nw = 3 + (len + 3) / 4;
  endtask

  task automatic verify_buf(input string nm);
    for (int w = 0; w < mdl_nw; w++) begin
      udp_txbuf_addr = w[AW-1:0];
      #1;
      check($sformatf("%s_w%0d", nm, w), udp_txbuf_rdata, mdl[w]);
    end
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first WAIT cycle.
  task automatic send_pkt(input string nm, input logic [31:0] ip, input logic [15:0] sp,
                          input logic [15:0] dp, input int n, input bit gaps,
                          input bit grant_in_rel);
    int i = 0;
    int guard = 0;
    int k;
    bit stalled = 0;
    bit early = 0;
    s_if.dst_ip = ip; s_if.src_port = sp; s_if.dst_port = dp;
    while (i < n && guard < 20000) begin
      if (gaps && $urandom_range(0, 3) == 0) s_if.s_tvalid = 1'b0;
      else begin
        s_if.s_tvalid = 1'b1;
        s_if.s_tdata  = pl[i];
        s_if.s_tlast  = (i == n - 1);
        if (s_if.s_tready) i++; else stalled = 1;
      end
      @(negedge clk);
      guard++;
      if (i >= 1) begin  // header must have been captured with byte 0
        s_if.dst_ip = ~ip; s_if.src_port = ~sp; s_if.dst_port = ~dp;
      end
    end
    s_if.s_tvalid = 1'b0; s_if.s_tlast = 1'b0;
    check({nm, "_accepted"}, i, n);
    check({nm, "_no_stall"}, 32'(stalled), 0);
    k = 1;
    while (!udp_txbuf_rel && k < 12) begin
      if (s_if.s_tready) early = 1;
      @(negedge clk);
      k++;
    end
    check({nm, "_rel_lat"}, k, 4);
    check({nm, "_ready_lo_hdr"}, 32'(early), 0);
    check({nm, "_ovf"}, 32'(overflow), 32'(n > MAXLEN));
    if (grant_in_rel) udp_txbuf_grant = 1'b1;
    @(negedge clk);
    udp_txbuf_grant = 1'b0;
    check({nm, "_rel_once"}, 32'(udp_txbuf_rel), 0);
    check({nm, "_wait_busy"}, 32'(s_if.s_tready), 0);
    model_pkt(ip, sp, dp, n);
  endtask

  // Holds a pending byte against the stalled packer, then grants.
  task automatic do_grant(input string nm, input int delay);
    bit leak = 0;
    for (int d = 0; d < delay; d++) begin
      s_if.s_tvalid = 1'b1; s_if.s_tdata = 8'($urandom);
      if (s_if.s_tready) leak = 1;
      @(negedge clk);
    end
    s_if.s_tvalid = 1'b0;
    check({nm, "_stall"}, 32'(leak), 0);
    udp_txbuf_grant = 1'b1;
    @(negedge clk);
    udp_txbuf_grant = 1'b0;
    check({nm, "_ready_g1"}, 32'(s_if.s_tready), 1);
  endtask

  initial begin
    s_if.s_tvalid = 1'b0; s_if.s_tlast = 1'b0; s_if.s_tdata = '0;
    s_if.dst_ip = '0; s_if.src_port = '0; s_if.dst_port = '0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(s_if.s_tready), 1);
    check("rst_rel", 32'(udp_txbuf_rel), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_tmo", 32'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    tv[0] = '{"foobar\n", 7, 32'h0a01a8c0, 16'd1111, 16'd1234,
              32'h0a01a8c0, 32'h045704d2, 32'h00000007, 32'h626f6f66};
    tv[1] = '{"A", 1, 32'h11223344, 16'h0001, 16'h0002,
              32'h11223344, 32'h00010002, 32'h00000001, 32'h00000041};
    tv[2] = '{"", 250, 32'hc0a80001, 16'hbeef, 16'h0035,
              32'hc0a80001, 32'hbeef0035, 32'h000000f4, 32'h03020100};
    for (int v = 0; v < 3; v++) begin
      logic [31:0] ew[4];
      pl.delete();
      for (int i = 0; i < tv[v].n; i++)
        pl.push_back(tv[v].txt.len() > 0 ? tv[v].txt[i] : 8'(i));
      send_pkt($sformatf("vec%0d", v), tv[v].ip, tv[v].sp, tv[v].dp, tv[v].n, 1'b0, 1'b0);
      ew[0] = tv[v].w0; ew[1] = tv[v].w1; ew[2] = tv[v].w2; ew[3] = tv[v].w3;
      for (int w = 0; w < 4; w++) begin
        udp_txbuf_addr = w[AW-1:0];
        #1;
        check($sformatf("vec%0d_tbl_w%0d", v, w), udp_txbuf_rdata, ew[w]);
      end
      if (v == 0) begin
        udp_txbuf_addr = 4; #1;
        check("vec0_tbl_w4", udp_txbuf_rdata, 32'h000a7261);
      end
      if (v == 2) begin
        udp_txbuf_addr = 63; #1;
        check("vec2_tbl_w63", udp_txbuf_rdata, 32'hf3f2f1f0);
      end
      @(negedge clk);
      verify_buf($sformatf("vec%0d", v));
      do_grant($sformatf("vec%0d", v), 3);
    end

    // Grant during REL is ignored; second packet waits, then overwrites header
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h90 + i));
    send_pkt("b2b_a", 32'hdeadbeef, 16'h1234, 16'h5678, 9, 1'b1, 1'b1);
    check("b2b_rel_grant_ignored", 32'(s_if.s_tready), 0);
    do_grant("b2b_a", 6);
    verify_buf("b2b_a_held");
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'(8'h30 + i));
    send_pkt("b2b_b", 32'h01020304, 16'h0a0b, 16'h0c0d, 5, 1'b0, 1'b0);
    verify_buf("b2b_b");
    do_grant("b2b_b", 1);

    // Reset in FILL after 5 bytes
    for (int i = 0; i < 5; i++) begin
      s_if.s_tvalid = 1'b1; s_if.s_tdata = 8'(8'hE0 + i); s_if.s_tlast = 1'b0;
      @(negedge clk);
    end
    s_if.s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(s_if.s_tready), 1);
    begin
      bit relseen = 0;
      for (int c = 0; c < 6; c++) begin
        if (udp_txbuf_rel) relseen = 1;
        @(negedge clk);
      end
      check("mid_rst_no_rel", 32'(relseen), 0);
    end
    pl.delete();
    pl.push_back(8'h61); pl.push_back(8'h62); pl.push_back(8'h63);
    send_pkt("post_rst", 32'haabbccdd, 16'd7, 16'd8, 3, 1'b0, 1'b0);
    udp_txbuf_addr = 2; #1;
    check("post_rst_len", udp_txbuf_rdata, 32'd3);
    @(negedge clk);
    verify_buf("post_rst");
    do_grant("post_rst", 0);

    // Randomized packets against the buffer model
    for (int r = 0; r < 25; r++) begin
      int n;
      n = (r % 5 == 4) ? $urandom_range(240, 260) : $urandom_range(1, 64);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_pkt($sformatf("rnd%0d", r), $urandom, 16'($urandom), 16'($urandom), n,
               1'b1, 1'($urandom_range(0, 1)));
      verify_buf($sformatf("rnd%0d", r));
      do_grant($sformatf("rnd%0d", r), $urandom_range(0, 8));
    end

    // No grant at all
    pl.delete();
    pl.push_back(8'h55); pl.push_back(8'h66);
    send_pkt("nogrant", 32'h0, 16'h0, 16'h0, 2, 1'b0, 1'b0);
`ifdef UDP_TX_PACKER_TIMEOUT_EN
    begin
      int k = 1;
      while (!timeout && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("tmo_delay", k, TMO);
      @(negedge clk);
      check("tmo_ready", 32'(s_if.s_tready), 1);
      check("tmo_once", 32'(timeout), 0);
    end
`else
    begin
      bit woke = 0;
      bit tmo = 0;
      for (int c = 0; c < 10000; c++) begin
        if (s_if.s_tready) woke = 1;
        if (timeout) tmo = 1;
        @(negedge clk);
      end
      check("hold_ready_lo", 32'(woke), 0);
      check("hold_no_tmo", 32'(tmo), 0);
      do_grant("hold", 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
